// File: rtl/unidade_busca_pkg.sv
// Shared widths, PC increment and FSM encoding for the instruction fetch unit.
package unidade_busca_pkg;

  localparam int LARGURA_PC      = 64;
  localparam int LARGURA_INSTR   = 32;
  localparam int INCREMENTO_PC   = 4;
  localparam int LARGURA_ENTRADA = LARGURA_PC + LARGURA_INSTR;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    BUSCANDO = 2'd1,
    CHEIO    = 2'd2
  } estado_t;

endpackage

// File: rtl/unidade_busca_fila.sv
// Synchronous FIFO holding {pc, instruction} entries; flush empties it in one cycle.
module fila_instrucao #(
  parameter int PROFUNDIDADE = 2,
  parameter int LARGURA      = 96,
  localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1,
  localparam int CW = $clog2(PROFUNDIDADE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [LARGURA-1:0] dado_entrada,
  output logic [LARGURA-1:0] dado_saida,
  output logic               vazia,
  output logic [CW-1:0]      ocupacao
);

  logic [LARGURA-1:0] memoria [PROFUNDIDADE];
  logic [PW-1:0]      leitura;
  logic [PW-1:0]      escrita;
  logic [CW-1:0]      contagem;
  logic               pop_ok;
  logic               push_ok;

  function automatic logic [PW-1:0] proximo_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(PROFUNDIDADE - 1)) begin
      return '0;
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign vazia      = (contagem == '0);
  assign ocupacao   = contagem;
  assign dado_saida = vazia ? '0 : memoria[leitura];
  // Guards keep the FIFO consistent even if the caller over/under-runs it.
  assign pop_ok     = pop & ~vazia;
  assign push_ok    = push & ((contagem < CW'(PROFUNDIDADE)) | pop_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      leitura  <= '0;
      escrita  <= '0;
      contagem <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        memoria[i] <= '0;
      end
    end else if (flush) begin
      leitura  <= '0;
      escrita  <= '0;
      contagem <= '0;
    end else begin
      if (push_ok) begin
        memoria[escrita] <= dado_entrada;
        escrita          <= proximo_ptr(escrita);
      end
      if (pop_ok) begin
        leitura <= proximo_ptr(leitura);
      end
      contagem <= contagem + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: PC register, fetch FSM and a small prefetch buffer toward decode.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter logic [63:0] PC_INICIAL   = 64'h0,
  parameter int          PROFUNDIDADE = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     habilita,
  input  logic                     desvio_valido,
  input  logic [LARGURA_PC-1:0]    desvio_alvo,
  output logic [LARGURA_PC-1:0]    mem_endereco,
  input  logic [LARGURA_INSTR-1:0] mem_instrucao,
  output logic                     saida_valida,
  input  logic                     saida_pronta,
  output logic [LARGURA_INSTR-1:0] saida_instrucao,
  output logic [LARGURA_PC-1:0]    saida_pc
);

  localparam int CW = $clog2(PROFUNDIDADE + 1);

  logic [LARGURA_PC-1:0]      pc;
  estado_t                    estado;
  estado_t                    proximo;
  logic                       vazia;
  logic [CW-1:0]              ocupacao;
  logic [CW-1:0]              ocup_prox;
  logic [LARGURA_ENTRADA-1:0] cabeca;
  logic                       transfere;
  logic                       empilha;

  assign mem_endereco    = {2'b00, pc[LARGURA_PC-1:2]};
  // A redirect masks the head so decode never consumes a stale instruction.
  assign saida_valida    = ~vazia & ~desvio_valido;
  assign transfere       = saida_valida & saida_pronta;
  assign empilha         = habilita & (estado == BUSCANDO) & ~desvio_valido &
                           ((ocupacao < CW'(PROFUNDIDADE)) | transfere);
  assign saida_pc        = cabeca[LARGURA_ENTRADA-1:LARGURA_INSTR];
  assign saida_instrucao = cabeca[LARGURA_INSTR-1:0];

  fila_instrucao #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARGURA_ENTRADA)
  ) u_fila (
    .clock        (clock),
    .reset        (reset),
    .push         (empilha),
    .pop          (transfere),
    .flush        (desvio_valido),
    .dado_entrada ({pc, mem_instrucao}),
    .dado_saida   (cabeca),
    .vazia        (vazia),
    .ocupacao     (ocupacao)
  );

  always_comb begin
    ocup_prox = ocupacao + CW'(empilha) - CW'(transfere);
    proximo   = estado;
    if (!habilita) begin
      proximo = PARADO;
    end else begin
      case (estado)
        PARADO: proximo = BUSCANDO;
        BUSCANDO: begin
          if (!desvio_valido && !transfere && (ocup_prox == CW'(PROFUNDIDADE))) begin
            proximo = CHEIO;
          end else begin
            proximo = BUSCANDO;
          end
        end
        CHEIO: begin
          if (transfere || desvio_valido) begin
            proximo = BUSCANDO;
          end else begin
            proximo = CHEIO;
          end
        end
        default: proximo = PARADO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= PARADO;
      pc     <= PC_INICIAL;
    end else begin
      estado <= proximo;
      if (desvio_valido) begin
        pc <= desvio_alvo & ~64'd3;
      end else if (empilha) begin
        pc <= pc + LARGURA_PC'(INCREMENTO_PC);
      end else begin
        pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Randomized and directed bench for unidade_busca against a queue-based fetch model.
module tb_unidade_busca;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk;
  logic        reset, habilita, desvio_valido, saida_pronta;
  logic [63:0] desvio_alvo, mem_endereco, saida_pc;
  logic [31:0] mem_instrucao, saida_instrucao;
  logic        saida_valida;

  logic        v_reset, v_habilita, v_valida;
  logic [63:0] v_end, v_pc;
  logic [31:0] v_mem, v_ins;

  logic [31:0] mem [64];
  ent_t        fila[$];
  logic [63:0] m_pc;
  int          m_est;  // 0 idle, 1 fetching, 2 full
  int          total = 0;
  int          passados = 0;

  assign mem_instrucao = mem[mem_endereco[5:0]];
  assign v_mem         = mem[v_end[5:0]];

  unidade_busca dut (
    .clock(clk), .reset(reset), .habilita(habilita),
    .desvio_valido(desvio_valido), .desvio_alvo(desvio_alvo),
    .mem_endereco(mem_endereco), .mem_instrucao(mem_instrucao),
    .saida_valida(saida_valida), .saida_pronta(saida_pronta),
    .saida_instrucao(saida_instrucao), .saida_pc(saida_pc)
  );

  unidade_busca #(.PC_INICIAL(64'hFFFF_FFFF_FFFF_FFFC)) u_volta (
    .clock(clk), .reset(v_reset), .habilita(v_habilita),
    .desvio_valido(1'b0), .desvio_alvo(64'h0),
    .mem_endereco(v_end), .mem_instrucao(v_mem),
    .saida_valida(v_valida), .saida_pronta(1'b0),
    .saida_instrucao(v_ins), .saida_pc(v_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the model applies the fetch rules to the inputs of that cycle.
  task automatic avanca();
    bit   val, pop, push;
    ent_t e;
    @(posedge clk);
    if (reset) begin
      fila.delete();
      m_pc  = 64'h0;
      m_est = 0;
    end else begin
      val  = (fila.size() != 0) && !desvio_valido;
      pop  = val && saida_pronta;
      push = habilita && (m_est == 1) && !desvio_valido && (fila.size() < 2 || pop);
      if (desvio_valido) begin
        fila.delete();
        m_pc = {desvio_alvo[63:2], 2'b00};
      end else begin
        if (pop) void'(fila.pop_front());
        if (push) begin
          e.pc  = m_pc;
          e.ins = mem[m_pc[7:2]];
          fila.push_back(e);
          m_pc  = m_pc + 64'd4;
        end
      end
      if (!habilita) m_est = 0;
      else if (m_est == 0) m_est = 1;
      else if (m_est == 1) m_est = (!desvio_valido && fila.size() == 2 && !pop) ? 2 : 1;
      else m_est = (pop || desvio_valido) ? 1 : 2;
    end
    @(negedge clk);
  endtask

  task automatic limpa_e_enche(input bit encher);
    reset = 1'b1; habilita = 1'b0; desvio_valido = 1'b0; saida_pronta = 1'b0;
    avanca();
    reset = 1'b0; habilita = 1'b1;
    if (encher) for (int i = 0; i < 4; i++) avanca();
  endtask

  task automatic test_reset();
    reset = 1'b1; habilita = 1'b0; desvio_valido = 1'b0; saida_pronta = 1'b1;
    desvio_alvo = 64'h0;
    avanca();
    reset = 1'b0;
    #1;
    total++;
    if (saida_valida !== 1'b0) $display("FAIL reset_valida: got %0b want 0", saida_valida);
    else passados++;
    total++;
    if (saida_instrucao !== 32'h0) $display("FAIL reset_instr: got %h want 0", saida_instrucao);
    else passados++;
    total++;
    if (saida_pc !== 64'h0) $display("FAIL reset_pc: got %h want 0", saida_pc);
    else passados++;
    total++;
    if (mem_endereco !== 64'h0) $display("FAIL reset_end: got %h want 0", mem_endereco);
    else passados++;
    avanca();
  endtask

  task automatic test_programa();
    logic [63:0] exp_end [5];
    logic [63:0] exp_pc  [3];
    logic [31:0] exp_ins [3];
    exp_end = '{64'd0, 64'd0, 64'd1, 64'd2, 64'd3};
    exp_pc  = '{64'h0, 64'h4, 64'h8};
    exp_ins = '{32'h00000000, 32'h00702083, 32'h01538FB3};
    limpa_e_enche(1'b0);
    saida_pronta = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (mem_endereco !== exp_end[c]) $display("FAIL prog_end[%0d]: got %h want %h", c, mem_endereco, exp_end[c]);
      else passados++;
      if (c >= 2) begin
        total++;
        if (saida_valida !== 1'b1 || saida_pc !== exp_pc[c-2] || saida_instrucao !== exp_ins[c-2])
          $display("FAIL prog_saida[%0d]: got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                   c, saida_valida, saida_pc, saida_instrucao, exp_pc[c-2], exp_ins[c-2]);
        else passados++;
      end
      avanca();
    end
  endtask

  task automatic test_pronta_baixa();
    limpa_e_enche(1'b0);
    for (int c = 0; c < 5; c++) avanca();
    #1;
    total++;
    if (mem_endereco !== 64'd2 || saida_pc !== 64'h0) $display("FAIL cheio_hold: got end=%h pc=%h want end=2 pc=0", mem_endereco, saida_pc);
    else passados++;
    saida_pronta = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (saida_valida !== 1'b1 || saida_pc !== 64'(4 * k))
        $display("FAIL cheio_ordem[%0d]: got v=%0b pc=%h want v=1 pc=%h", k, saida_valida, saida_pc, 64'(4 * k));
      else passados++;
      avanca();
    end
  endtask

  task automatic test_desvio(input logic [63:0] alvo);
    limpa_e_enche(1'b1);
    desvio_valido = 1'b1; desvio_alvo = alvo;
    #1;
    total++;
    if (saida_valida !== 1'b0) $display("FAIL desvio_mascara(%h): got %0b want 0", alvo, saida_valida);
    else passados++;
    avanca();
    desvio_valido = 1'b0;
    #1;
    total++;
    if (mem_endereco !== 64'd6) $display("FAIL desvio_end(%h): got %h want 6", alvo, mem_endereco);
    else passados++;
    avanca();
    #1;
    total++;
    if (saida_valida !== 1'b1 || saida_pc !== 64'h18 || saida_instrucao !== 32'h03DE2423)
      $display("FAIL desvio_saida(%h): got v=%0b pc=%h ins=%h want v=1 pc=18 ins=03de2423",
               alvo, saida_valida, saida_pc, saida_instrucao);
    else passados++;
  endtask

  task automatic test_reset_meio();
    limpa_e_enche(1'b1);
    reset = 1'b1; saida_pronta = 1'b1; desvio_valido = 1'b1; desvio_alvo = 64'h40;
    avanca();
    reset = 1'b0; desvio_valido = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (saida_valida !== 1'b0 || mem_endereco !== 64'h0)
        $display("FAIL reset_meio[%0d]: got v=%0b end=%h want v=0 end=0", k, saida_valida, mem_endereco);
      else passados++;
      avanca();
    end
  endtask

  task automatic test_volta();
    v_reset = 1'b1; v_habilita = 1'b0;
    avanca();
    v_reset = 1'b0;
    #1;
    total++;
    if (v_end !== 64'h3FFF_FFFF_FFFF_FFFF) $display("FAIL volta_inicio: got %h want 3fffffffffffffff", v_end);
    else passados++;
    v_habilita = 1'b1;
    avanca();
    avanca();
    #1;
    total++;
    if (v_end !== 64'h0 || v_valida !== 1'b1 || v_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL volta_wrap: got end=%h v=%0b pc=%h want end=0 v=1 pc=fffffffffffffffc", v_end, v_valida, v_pc);
    else passados++;
  endtask

  task automatic test_aleatorio();
    logic [63:0] ep;
    logic [31:0] ei;
    bit          ev;
    limpa_e_enche(1'b0);
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 99) < 2);
      habilita      = ($urandom_range(0, 9) != 0);
      saida_pronta  = $urandom_range(0, 1);
      desvio_valido = ($urandom_range(0, 19) == 0);
      desvio_alvo   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      #1;
      ev = (fila.size() != 0) && !desvio_valido;
      ep = (fila.size() != 0) ? fila[0].pc : 64'h0;
      ei = (fila.size() != 0) ? fila[0].ins : 32'h0;
      total++;
      if (mem_endereco !== (m_pc >> 2)) $display("FAIL rnd_end[%0d]: got %h want %h", c, mem_endereco, m_pc >> 2);
      else passados++;
      total++;
      if (saida_valida !== ev) $display("FAIL rnd_valida[%0d]: got %0b want %0b", c, saida_valida, ev);
      else passados++;
      total++;
      if (saida_pc !== ep || saida_instrucao !== ei)
        $display("FAIL rnd_cabeca[%0d]: got pc=%h ins=%h want pc=%h ins=%h", c, saida_pc, saida_instrucao, ep, ei);
      else passados++;
      avanca();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00000000;
    mem[1] = 32'h00702083;
    mem[2] = 32'h01538FB3;
    mem[6] = 32'h03DE2423;
    v_reset = 1'b1; v_habilita = 1'b0;
    test_reset();
    test_programa();
    test_pronta_baixa();
    test_desvio(64'h18);
    test_desvio(64'h1B);
    test_reset_meio();
    test_volta();
    test_aleatorio();
    $display("%0d/%0d checks passed", passados, total);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter PC_INICIAL, default 64'h0, byte address loaded into PC on reset.
REQ-002 Parameter PROFUNDIDADE, default 2, prefetch buffer depth in entries; only value 2 is required to work.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 habilita  input  1  fetch enable; 0 = no new fetches, buffer still drains.
REQ-006 desvio_valido  input  1  redirect request (branch/jump taken).
REQ-007 desvio_alvo  input  64  redirect target byte address.
REQ-008 mem_endereco  output  64  word index to instruction memory, pc >> 2, zero-extended.
REQ-009 mem_instrucao  input  32  instruction word from memory, combinationally valid in the same cycle as mem_endereco.
REQ-010 saida_valida  output  1  head of buffer valid to decode.
REQ-011 saida_pronta  input  1  decode accepts head; transfer = saida_valida & saida_pronta.
REQ-012 saida_instrucao  output  32  instruction at head; 0 when buffer empty.
REQ-013 saida_pc  output  64  byte address of head instruction; 0 when buffer empty.

Function
REQ-014 PC register is a 64-bit byte address; mem_endereco SHALL be driven combinationally from PC only.
REQ-015 Push: in state BUSCANDO with a free slot (or a slot freed by a same-cycle transfer), {pc, mem_instrucao} SHALL be written to the buffer tail and PC SHALL advance by 4.
REQ-016 PC arithmetic SHALL wrap modulo 2^64.
REQ-017 Latency: an instruction fetched at cycle N SHALL appear with saida_valida=1 at cycle N+1; sustained throughput 1 instruction/cycle.
REQ-018 Buffer order SHALL be strict FIFO; no loss or duplication under any saida_pronta pattern.
REQ-019 Occupancy counter 0..PROFUNDIDADE; push and pop in the same cycle when full SHALL leave it full and be legal.
REQ-020 FSM states: PARADO, BUSCANDO, CHEIO.
REQ-021 PARADO->BUSCANDO when habilita=1; BUSCANDO->CHEIO when occupancy reaches PROFUNDIDADE with no pop; CHEIO->BUSCANDO on pop or redirect; any state->PARADO when habilita=0 (buffer contents retained).
REQ-022 Redirect: in a cycle with desvio_valido=1, the buffer SHALL be flushed, no push occurs, and PC SHALL load {desvio_alvo[63:2], 2'b00}.
REQ-023 Redirect priority: saida_valida SHALL be forced 0 in any cycle with desvio_valido=1, so no transfer occurs.
REQ-024 Redirect SHALL be honoured in every state, including PARADO.
REQ-025 With habilita=0, PC SHALL hold and mem_endereco SHALL remain stable.

Reset
REQ-026 On reset: PC=PC_INICIAL, buffer empty, occupancy 0, state PARADO, saida_valida=0, saida_instrucao=0, saida_pc=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries and override any simultaneous redirect or transfer.

Structure
REQ-028 Shared package holds LARGURA_PC=64, LARGURA_INSTR=32, INCREMENTO_PC=4 and the FSM state encoding.
REQ-029 Buffer SHALL be a sub-module fila_instrucao (synchronous FIFO with push, pop, flush, occupancy count).

Verification
REQ-030 Reset, habilita=1, saida_pronta=1, memory loaded with the team test program -> mem_endereco 0,1,2; saida_pc 0,4,8; saida_instrucao 32'h00000000, 32'h00702083, 32'h01538FB3 on consecutive cycles starting the cycle after the first fetch.
REQ-031 saida_pronta=0 for 5 cycles after the start -> occupancy saturates at 2, PC holds at 8, state CHEIO; on release, output saida_pc 0,4,8 in order, with no gap or duplicate.
REQ-032 Buffer full, desvio_valido=1 with alvo 64'h18 at cycle N -> saida_valida=0 at N, mem_endereco=6 at N+1, saida_pc=64'h18 and saida_instrucao=32'h03DE2423 valid at N+2.
REQ-033 Redirect alvo 64'h1B -> behaves identically to alvo 64'h18.
REQ-034 Reset asserted for 1 cycle with full buffer and saida_pronta=1 -> next cycle saida_valida=0, PC=0, state PARADO.
REQ-035 PC_INICIAL=64'hFFFF_FFFF_FFFF_FFFC -> after one push PC=0 and mem_endereco=0.
